// File: rtl/branch_resolve_stage.sv
// Execute-to-memory register stage: resolves conditional branches against NZCV,
// emits a one-cycle taken pulse and squashes the wrong-path shadow behind it.
module branch_resolve_stage #(
  parameter int WORD   = 32,
  parameter int SHADOW = 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            valid_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [WORD-1:0] alu_result_i,
  input  logic [3:0]      status_reg_i,
  input  logic            is_cond_branch_i,
  input  logic [3:0]      cond_code_i,
  input  logic [WORD-1:0] branch_target_i,
  input  logic            reg_wr_en_i,
  input  logic [3:0]      reg_dest_i,
  input  logic            mem_rd_en_i,
  input  logic            mem_wr_en_i,
  input  logic [WORD-1:0] store_data_i,
  output logic            valid_o,
  output logic [WORD-1:0] alu_result_o,
  output logic [WORD-1:0] store_data_o,
  output logic            reg_wr_en_o,
  output logic            mem_rd_en_o,
  output logic            mem_wr_en_o,
  output logic [3:0]      reg_dest_o,
  output logic            branch_taken_o,
  output logic [WORD-1:0] branch_target_o
);

  localparam logic [1:0] SHADOW_LD = SHADOW[1:0];

  logic [1:0] shadow_cnt;
  logic       cond_pass;
  logic       flag_n, flag_z, flag_c, flag_v;

  assign {flag_n, flag_z, flag_c, flag_v} = status_reg_i;

  always_comb begin
    cond_pass = 1'b0;
    case (cond_code_i)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_o         <= 1'b0;
      alu_result_o    <= '0;
      store_data_o    <= '0;
      reg_wr_en_o     <= 1'b0;
      mem_rd_en_o     <= 1'b0;
      mem_wr_en_o     <= 1'b0;
      reg_dest_o      <= '0;
      branch_taken_o  <= 1'b0;
      branch_target_o <= '0;
      shadow_cnt      <= '0;
    end else if (flush_i) begin
      valid_o        <= 1'b0;
      reg_wr_en_o    <= 1'b0;
      mem_rd_en_o    <= 1'b0;
      mem_wr_en_o    <= 1'b0;
      branch_taken_o <= 1'b0;
      shadow_cnt     <= '0;
    end else if (stall_i) begin
      // payload holds, but the taken pulse must never stretch
      branch_taken_o <= 1'b0;
    end else begin
      branch_taken_o <= 1'b0;
      alu_result_o   <= alu_result_i;
      store_data_o   <= store_data_i;
      reg_dest_o     <= reg_dest_i;
      if (valid_i && shadow_cnt == 2'd0) begin
        valid_o     <= 1'b1;
        reg_wr_en_o <= reg_wr_en_i;
        mem_rd_en_o <= mem_rd_en_i;
        mem_wr_en_o <= mem_wr_en_i;
        if (is_cond_branch_i && cond_pass) begin
          branch_taken_o  <= 1'b1;
          branch_target_o <= branch_target_i;
          shadow_cnt      <= SHADOW_LD;
        end
      end else begin
        valid_o     <= 1'b0;
        reg_wr_en_o <= 1'b0;
        mem_rd_en_o <= 1'b0;
        mem_wr_en_o <= 1'b0;
        if (valid_i) shadow_cnt <= shadow_cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed bench for branch_resolve_stage: reset, condition sweep, shadow squash,
// stall, flush and bubble cases, plus a SHADOW=0 instance for back-to-back branches.
module tb_branch_resolve_stage;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_i, stall_i, flush_i;
  logic [31:0] alu_result_i, branch_target_i, store_data_i;
  logic [3:0]  status_reg_i, cond_code_i, reg_dest_i;
  logic        is_cond_branch_i, reg_wr_en_i, mem_rd_en_i, mem_wr_en_i;

  logic        valid_o, reg_wr_en_o, mem_rd_en_o, mem_wr_en_o, branch_taken_o;
  logic [31:0] alu_result_o, store_data_o, branch_target_o;
  logic [3:0]  reg_dest_o;

  logic        z_valid_o, z_reg_wr_en_o, z_mem_rd_en_o, z_mem_wr_en_o, z_branch_taken_o;
  logic [31:0] z_alu_result_o, z_store_data_o, z_branch_target_o;
  logic [3:0]  z_reg_dest_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  branch_resolve_stage #(.WORD(32), .SHADOW(1)) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .stall_i(stall_i),
    .flush_i(flush_i), .alu_result_i(alu_result_i), .status_reg_i(status_reg_i),
    .is_cond_branch_i(is_cond_branch_i), .cond_code_i(cond_code_i),
    .branch_target_i(branch_target_i), .reg_wr_en_i(reg_wr_en_i),
    .reg_dest_i(reg_dest_i), .mem_rd_en_i(mem_rd_en_i), .mem_wr_en_i(mem_wr_en_i),
    .store_data_i(store_data_i), .valid_o(valid_o), .alu_result_o(alu_result_o),
    .store_data_o(store_data_o), .reg_wr_en_o(reg_wr_en_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o), .reg_dest_o(reg_dest_o),
    .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o)
  );

  branch_resolve_stage #(.WORD(32), .SHADOW(0)) u_dut_s0 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .stall_i(stall_i),
    .flush_i(flush_i), .alu_result_i(alu_result_i), .status_reg_i(status_reg_i),
    .is_cond_branch_i(is_cond_branch_i), .cond_code_i(cond_code_i),
    .branch_target_i(branch_target_i), .reg_wr_en_i(reg_wr_en_i),
    .reg_dest_i(reg_dest_i), .mem_rd_en_i(mem_rd_en_i), .mem_wr_en_i(mem_wr_en_i),
    .store_data_i(store_data_i), .valid_o(z_valid_o), .alu_result_o(z_alu_result_o),
    .store_data_o(z_store_data_o), .reg_wr_en_o(z_reg_wr_en_o),
    .mem_rd_en_o(z_mem_rd_en_o), .mem_wr_en_o(z_mem_wr_en_o), .reg_dest_o(z_reg_dest_o),
    .branch_taken_o(z_branch_taken_o), .branch_target_o(z_branch_target_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    valid_i = 0; stall_i = 0; flush_i = 0; alu_result_i = '0; branch_target_i = '0;
    store_data_i = '0; status_reg_i = '0; cond_code_i = '0; reg_dest_i = '0;
    is_cond_branch_i = 0; reg_wr_en_i = 0; mem_rd_en_i = 0; mem_wr_en_i = 0;
  endtask

  // Architectural formulation: base test from cc[3:1], inverted by cc[0]; 1111 never passes.
  function automatic logic exp_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (cc == 4'hF) return 1'b0;
    return cc[0] ? ~base : base;
  endfunction

  initial begin
    logic e;
    clr();
    rst_n_i = 0;
    step(); step();
    chk("rst_valid", valid_o, 0);
    chk("rst_alu", alu_result_o, 0);
    chk("rst_taken", branch_taken_o, 0);
    chk("rst_target", branch_target_o, 0);
    chk("rst_enables", {reg_wr_en_o, mem_rd_en_o, mem_wr_en_o}, 0);
    rst_n_i = 1;

    // reset mid-operation with counter loaded
    valid_i = 1; is_cond_branch_i = 1; cond_code_i = 4'h0; status_reg_i = 4'b0100;
    branch_target_i = 32'h40;
    step();
    chk("mid_beq_taken", branch_taken_o, 1);
    clr(); valid_i = 1; alu_result_i = 32'h1234; reg_wr_en_i = 1; rst_n_i = 0;
    step();
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_alu", alu_result_o, 0);
    chk("mid_rst_taken", branch_taken_o, 0);
    chk("mid_rst_wr", reg_wr_en_o, 0);
    rst_n_i = 1;
    step();
    chk("resend_valid", valid_o, 1);
    chk("resend_alu", alu_result_o, 32'h1234);
    chk("resend_wr", reg_wr_en_o, 1);

    // condition sweep; each branch followed by a filler that drains the shadow
    for (int cc = 0; cc < 16; cc++) begin
      for (int f = 0; f < 16; f++) begin
        clr(); valid_i = 1; is_cond_branch_i = 1; cond_code_i = cc[3:0];
        status_reg_i = f[3:0]; branch_target_i = 32'h100;
        e = exp_cond(cc[3:0], f[3:0]);
        step();
        chk($sformatf("sweep_taken_cc%0d_f%0d", cc, f), branch_taken_o, e);
        chk($sformatf("sweep_valid_cc%0d_f%0d", cc, f), valid_o, 1);
        if (e) chk($sformatf("sweep_tgt_cc%0d_f%0d", cc, f), branch_target_o, 32'h100);
        clr(); valid_i = 1; alu_result_i = 32'hF00 + cc * 16 + f;
        step();
        chk($sformatf("sweep_fill_cc%0d_f%0d", cc, f), valid_o, !e);
        chk($sformatf("sweep_fill_tk_cc%0d_f%0d", cc, f), branch_taken_o, 0);
      end
    end

    // shadow squash: BEQ taken, ADD squashed, SUB passes
    clr(); valid_i = 1; is_cond_branch_i = 1; cond_code_i = 4'h0; status_reg_i = 4'b0100;
    branch_target_i = 32'h200;
    step();
    chk("sq_beq_valid", valid_o, 1);
    chk("sq_beq_taken", branch_taken_o, 1);
    chk("sq_beq_tgt", branch_target_o, 32'h200);
    clr(); valid_i = 1; reg_wr_en_i = 1; reg_dest_i = 4'd3; alu_result_i = 32'h11;
    step();
    chk("sq_add_valid", valid_o, 0);
    chk("sq_add_wr", reg_wr_en_o, 0);
    chk("sq_add_taken", branch_taken_o, 0);
    clr(); valid_i = 1; reg_wr_en_i = 1; reg_dest_i = 4'd4; alu_result_i = 32'h22;
    step();
    chk("sq_sub_valid", valid_o, 1);
    chk("sq_sub_wr", reg_wr_en_o, 1);
    chk("sq_sub_alu", alu_result_o, 32'h22);
    chk("sq_sub_dest", reg_dest_o, 4);

    // stall hold after a taken branch
    clr(); valid_i = 1; is_cond_branch_i = 1; cond_code_i = 4'hE; alu_result_i = 32'h55;
    reg_dest_i = 4'd5; branch_target_i = 32'h300;
    step();
    chk("st_cap_taken", branch_taken_o, 1);
    clr(); stall_i = 1; valid_i = 1; alu_result_i = 32'h99; reg_dest_i = 4'd9;
    is_cond_branch_i = 1; cond_code_i = 4'hE; branch_target_i = 32'h999;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("st_taken_%0d", i), branch_taken_o, 0);
      chk($sformatf("st_valid_%0d", i), valid_o, 1);
      chk($sformatf("st_alu_%0d", i), alu_result_o, 32'h55);
      chk($sformatf("st_dest_%0d", i), reg_dest_o, 5);
      chk($sformatf("st_tgt_%0d", i), branch_target_o, 32'h300);
    end
    clr(); valid_i = 1; alu_result_i = 32'h66;
    step();
    chk("st_after_squash", valid_o, 0);
    step();
    chk("st_after_pass", valid_o, 1);

    // flush beats branch
    clr(); valid_i = 1; is_cond_branch_i = 1; cond_code_i = 4'h1; status_reg_i = 4'b0000;
    branch_target_i = 32'h400; flush_i = 1;
    step();
    chk("fl_taken", branch_taken_o, 0);
    chk("fl_valid", valid_o, 0);
    clr(); valid_i = 1; reg_wr_en_i = 1; alu_result_i = 32'h77;
    step();
    chk("fl_next_valid", valid_o, 1);
    chk("fl_next_wr", reg_wr_en_o, 1);
    chk("fl_next_alu", alu_result_o, 32'h77);

    // bubble with counter loaded: counter must survive the bubble
    clr(); valid_i = 1; is_cond_branch_i = 1; cond_code_i = 4'hE;
    step();
    chk("bb_taken", branch_taken_o, 1);
    clr(); mem_wr_en_i = 1;
    step();
    chk("bb_valid", valid_o, 0);
    chk("bb_memwr", mem_wr_en_o, 0);
    clr(); valid_i = 1; mem_wr_en_i = 1;
    step();
    chk("bb_sq_valid", valid_o, 0);
    chk("bb_sq_memwr", mem_wr_en_o, 0);
    step();
    chk("bb_pass_valid", valid_o, 1);
    chk("bb_pass_memwr", mem_wr_en_o, 1);

    // back-to-back taken branches: SHADOW=1 blocks the second, SHADOW=0 fires both
    clr(); valid_i = 1; is_cond_branch_i = 1; cond_code_i = 4'hE; branch_target_i = 32'h500;
    step();
    chk("b2b_s1_first", branch_taken_o, 1);
    chk("b2b_s0_first", z_branch_taken_o, 1);
    branch_target_i = 32'h600;
    step();
    chk("b2b_s1_second", branch_taken_o, 0);
    chk("b2b_s1_valid", valid_o, 0);
    chk("b2b_s0_second", z_branch_taken_o, 1);
    chk("b2b_s0_tgt", z_branch_target_o, 32'h600);
    chk("b2b_s0_valid", z_valid_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_stage.md
Name: branch_resolve_stage

Overview:
- Execute-to-memory stage directly downstream of the ALU wrapper.
- Consumes the ALU result and the registered NZCV status, and evaluates the condition code of conditional branches.
- Registers the instruction into the memory stage and issues a one-cycle branch-taken pulse with its target.
- Squashes the wrong-path instructions that entered execute behind a taken branch.

Parameters:
- WORD, 32, datapath width.
- SHADOW, 1, number of younger valid instructions squashed after a taken branch (range 0..3).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  synchronous reset, active low.
- valid_i  in  1  instruction present from execute.
- stall_i  in  1  memory stage not accepting; hold all registered outputs.
- flush_i  in  1  external kill, e.g. exception.
- alu_result_i  in  WORD  ALU result.
- status_reg_i  in  4  {N,Z,C,V}, bit 3 = N.
- is_cond_branch_i  in  1  instruction is a conditional branch.
- cond_code_i  in  4  ARM condition field.
- branch_target_i  in  WORD  computed target address.
- reg_wr_en_i  in  1  register writeback enable.
- reg_dest_i  in  4  destination register.
- mem_rd_en_i, mem_wr_en_i  in  1 each  load/store enables.
- store_data_i  in  WORD  store data.
- valid_o  out  1  registered valid into memory stage.
- alu_result_o, store_data_o  out  WORD  registered copies.
- reg_wr_en_o, mem_rd_en_o, mem_wr_en_o  out  1  registered, forced 0 when valid_o=0.
- reg_dest_o  out  4  registered.
- branch_taken_o  out  1  one-cycle pulse.
- branch_target_o  out  WORD  valid while branch_taken_o=1.

Behaviour:
- Reset is synchronous, active low.
  - All outputs reset to 0.
  - Shadow counter resets to 0.
- Priority, highest first: reset, flush_i, stall_i, normal capture.
- Accept condition: accept = valid_i && !stall_i && !flush_i.
- On accept with shadow counter 0:
  - Register all payload; valid_o=1.
  - If is_cond_branch_i and the condition passes: branch_taken_o=1 next cycle, branch_target_o=branch_target_i, shadow counter loads SHADOW.
  - A branch instruction itself does not write registers or memory. Its enable bits are registered as given (the decoder drives them 0).
- On accept with shadow counter > 0:
  - The instruction is squashed: valid_o=0 and all enables 0.
  - The counter decrements by 1.
  - A squashed branch never fires.
- !valid_i && !stall_i: valid_o=0, enables 0, counter unchanged.
- stall_i=1:
  - Every payload output holds.
  - branch_taken_o still drops after its single cycle; the pulse is never stretched or repeated.
  - Counter holds.
- flush_i=1 (with or without stall):
  - Next cycle valid_o=0, all enables 0, branch_taken_o=0, counter cleared.
  - A branch resolving in the same cycle as flush_i is discarded.
- Latency: 1 cycle from input to output.
- Condition evaluation is combinational on the current status_reg_i:
  - 0000 EQ: Z.
  - 0001 NE: !Z.
  - 0010 CS: C.
  - 0011 CC: !C.
  - 0100 MI: N.
  - 0101 PL: !N.
  - 0110 VS: V.
  - 0111 VC: !V.
  - 1000 HI: C&!Z.
  - 1001 LS: !C|Z.
  - 1010 GE: N==V.
  - 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V).
  - 1101 LE: Z|(N!=V).
  - 1110 AL: 1.
  - 1111: never taken (reserved).
- Non-branch instructions ignore cond_code_i and always pass.
- Back-to-back: a passing branch accepted while counter=0 blocks any branch in the next SHADOW accepted slots. With SHADOW=0 two consecutive taken branches each pulse.

Test Plan:
- Reset mid-operation: valid_i=1 with payload alu_result_i=32'h1234, then rst_n_i=0 for one cycle -> next cycle all outputs 0 and counter 0. Release, resend -> alu_result_o=32'h1234 and valid_o=1 one cycle later.
- Condition sweep: for each cond_code 0..15 against each of the 16 NZCV values, issue a branch with target 32'h100 -> branch_taken_o matches the table. Code 1111 never fires; 1110 always fires.
- Shadow squash, SHADOW=1: BEQ with Z=1 followed by ADD (reg_wr_en_i=1) then SUB -> BEQ outputs valid_o=1 with branch_taken_o=1 for 1 cycle. ADD emerges with valid_o=0, reg_wr_en_o=0. SUB emerges with valid_o=1.
- Stall hold: taken branch captured, then stall_i=1 for 3 cycles -> branch_taken_o high only the first cycle; payload and valid_o constant through all 3 cycles.
- Flush beats branch: BNE with Z=0 and flush_i=1 in the same cycle -> branch_taken_o stays 0, valid_o=0. The next instruction is not squashed.
- Empty bubble: valid_i=0 with mem_wr_en_i=1 -> mem_wr_en_o=0, valid_o=0, counter unchanged.
